// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
//   uart_tx_state_e : transmit FSM states
//   baud_cycles()   : clock cycles per line bit (integer divide)
//   UART_DATA_BITS  : payload bits per frame
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } uart_tx_state_e;

  function automatic int unsigned baud_cycles(int unsigned clk_freq, int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Bus-side handshake and line signals of the UART transmitter.
//   send   : level-sensitive transmit request (master -> slave)
//   din    : byte to transmit, sampled at frame start (master -> slave)
//   busy   : frame in progress (slave -> master)
//   tx_out : serial line, idle high (slave -> master)
//   done   : one-cycle pulse after the stop bit (slave -> master)
interface uart_tx_if;
  import uart_pkg::*;

  logic                      send;
  logic [UART_DATA_BITS-1:0] din;
  logic                      busy;
  logic                      tx_out;
  logic                      done;

  modport master (
    output send,
    output din,
    input  busy,
    input  tx_out,
    input  done
  );

  modport slave (
    input  send,
    input  din,
    output busy,
    output tx_out,
    output done
  );

endinterface

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..BAUD_CLOCK_CYCLES-1 while enabled and wraps.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear (takes priority over en)
//   en   : count enable
//   tick : high on the last cycle of each bit period
module uart_baud_timer #(
  parameter int unsigned BAUD_CLOCK_CYCLES = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (BAUD_CLOCK_CYCLES > 1) ? $clog2(BAUD_CLOCK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_CLOCK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : uart_tx_if slave modport (send/din in, busy/tx_out/done out)
// Build option: define UART_TX_TWO_STOP_EN for two stop bits (12-bit frame).
// tx_out, busy and done are registered from the next-state values, so tx_out
// changes on the same edge that samples send.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter int unsigned PARITY        = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus_io
);

  localparam int unsigned BaudCycles = baud_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam logic [2:0]  LastBit    = 3'(UART_DATA_BITS - 1);

  uart_tx_state_e            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      par_q, par_d;
  logic                      tx_out_q, tx_out_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      tick;
  logic                      stop_last;

  uart_baud_timer #(
    .BAUD_CLOCK_CYCLES(BaudCycles)
  ) u_baud_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_d != state_q),
    .en  (state_q != StIdle),
    .tick(tick)
  );

  // bit_cnt has wrapped to 0 after the data bits, so it doubles as the stop-bit counter.
`ifdef UART_TX_TWO_STOP_EN
  assign stop_last = (bit_cnt_q == 3'd1);
`else
  assign stop_last = 1'b1;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.send) begin
          shift_d   = bus_io.din;
          par_d     = (^bus_io.din) ^ PARITY[0];
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LastBit) state_d = StPar;
        end
      end
      StPar: begin
        if (tick) state_d = StStop;
      end
      StStop: begin
        if (tick) begin
          if (stop_last) begin
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    tx_out_d = 1'b1;
    unique case (state_d)
      StIdle:  tx_out_d = 1'b1;
      StStart: tx_out_d = 1'b0;
      StData:  tx_out_d = shift_d[0];
      StPar:   tx_out_d = par_d;
      StStop:  tx_out_d = 1'b1;
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_q == StStop) && (state_d == StIdle);
  end

  assign bus_io.tx_out = tx_out_q;
  assign bus_io.busy   = busy_q;
  assign bus_io.done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Runs at 160 Hz / 10 baud so a bit lasts 16 clocks,
// keeping every frame short. One odd-parity and one even-parity instance.
module tb_uart_tx;

  localparam int N = 16;  // 160 / 10
`ifdef UART_TX_TWO_STOP_EN
  localparam int NBITS = 12;
`else
  localparam int NBITS = 11;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_if if_odd ();
  uart_tx_if if_even ();

  uart_tx #(
    .CLK_FREQUENCY(160),
    .BAUD_RATE    (10),
    .PARITY       (1)
  ) dut_odd (
    .clk   (clk),
    .rst   (rst),
    .bus_io(if_odd.slave)
  );

  uart_tx #(
    .CLK_FREQUENCY(160),
    .BAUD_RATE    (10),
    .PARITY       (0)
  ) dut_even (
    .clk   (clk),
    .rst   (rst),
    .bus_io(if_even.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input logic par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return par;
    return 1'b1;
  endfunction

  task automatic start(input bit even, input logic [7:0] d);
    if (even) begin
      if_even.din  = d;
      if_even.send = 1'b1;
    end else begin
      if_odd.din  = d;
      if_odd.send = 1'b1;
    end
    step();
  endtask

  // Entered on cycle 0 of a frame; leaves on the cycle carrying done.
  task automatic check_frame(input bit even, input logic [7:0] d, input logic par,
                             input int drop_at, input int chg_at, input logic [7:0] chg_val,
                             input string tag);
    logic tx, bz, dn;
    for (int b = 0; b < NBITS; b++) begin
      int bad_tx  = 0;
      int bad_ctl = 0;
      for (int c = 0; c < N; c++) begin
        tx = even ? if_even.tx_out : if_odd.tx_out;
        bz = even ? if_even.busy : if_odd.busy;
        dn = even ? if_even.done : if_odd.done;
        if (tx !== exp_bit(d, par, b)) bad_tx++;
        if (bz !== 1'b1 || dn !== 1'b0) bad_ctl++;
        if (b * N + c == drop_at) begin
          if (even) if_even.send = 1'b0;
          else if_odd.send = 1'b0;
        end
        if (b * N + c == chg_at) begin
          if (even) if_even.din = chg_val;
          else if_odd.din = chg_val;
        end
        step();
      end
      chk($sformatf("%s bit%0d tx bad cycles", tag, b), bad_tx, 0);
      chk($sformatf("%s bit%0d busy/done bad cycles", tag, b), bad_ctl, 0);
    end
    chk({tag, " done pulse"}, even ? if_even.done : if_odd.done, 1);
    chk({tag, " busy after"}, even ? if_even.busy : if_odd.busy, 0);
    chk({tag, " tx idle after"}, even ? if_even.tx_out : if_odd.tx_out, 1);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    if_odd.send  = 1'b0;
    if_odd.din   = 8'h00;
    if_even.send = 1'b0;
    if_even.din  = 8'h00;

    // Reset
    repeat (5) step();
    chk("reset tx", if_odd.tx_out, 1);
    chk("reset busy", if_odd.busy, 0);
    chk("reset done", if_odd.done, 0);
    chk("reset tx even", if_even.tx_out, 1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (if_odd.tx_out !== 1'b1 || if_odd.busy !== 1'b0 || if_odd.done !== 1'b0) bad++;
      step();
    end
    chk("idle 1000 cycles bad", bad, 0);

    // Single frame 0x41, odd parity -> 1
    start(0, 8'h41);
    check_frame(0, 8'h41, 1'b1, 0, -1, 8'h00, "odd41");
    step();
    chk("odd41 done single pulse", if_odd.done, 0);
    chk("odd41 stays idle", if_odd.tx_out, 1);

    // Parity sweep
    start(0, 8'hFF);
    check_frame(0, 8'hFF, 1'b1, 0, -1, 8'h00, "oddFF");
    step();
    start(0, 8'h07);
    check_frame(0, 8'h07, 1'b0, 0, -1, 8'h00, "odd07");
    step();
    start(0, 8'h00);
    check_frame(0, 8'h00, 1'b1, 0, -1, 8'h00, "odd00");
    step();
    start(1, 8'h41);
    check_frame(1, 8'h41, 1'b0, 0, -1, 8'h00, "even41");
    step();

    // Back-to-back: send held, din changes mid-frame
    start(0, 8'h55);
    check_frame(0, 8'h55, 1'b1, -1, 3 * N, 8'hAA, "b2b55");
    step();
    check_frame(0, 8'hAA, 1'b1, 1, -1, 8'h00, "b2bAA");
    step();
    chk("b2b idle tx", if_odd.tx_out, 1);
    chk("b2b idle busy", if_odd.busy, 0);

    // Reset during data bit 3 (0x41 bit 3 is 0, so the line is low)
    start(0, 8'h41);
    if_odd.send = 1'b0;
    repeat (4 * N + N / 2) step();
    chk("pre-reset busy", if_odd.busy, 1);
    chk("pre-reset tx", if_odd.tx_out, 0);
    rst = 1'b1;
    #1;
    chk("async reset tx", if_odd.tx_out, 1);
    chk("async reset busy", if_odd.busy, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if_odd.done !== 1'b0) bad++;
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (if_odd.done !== 1'b0 || if_odd.tx_out !== 1'b1) bad++;
      step();
    end
    chk("post-reset no done", bad, 0);
    start(0, 8'h3C);
    check_frame(0, 8'h3C, 1'b1, 0, -1, 8'h00, "odd3C");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
